// File: rtl/bat_amateur_bus_arbiter.sv
// Shared RAM bus arbiter: the CPU owns the bus in RUN/HALTING, the loader
// owns it in LOAD/RELEASE; the CPU is held in HALT while the loader is active.
module bat_amateur_bus_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int HALT_SETTLE   = 2,
  parameter int BOOT_LOAD     = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     LOAD_REQ,
  input  logic                     LOAD_VALID,
  input  logic                     LOAD_LAST,
  input  logic [ADDRESS_WIDTH-1:0] LOAD_ADDR,
  input  logic [DATA_WIDTH-1:0]    LOAD_DATA,
  output logic                     LOAD_READY,
  output logic                     LOAD_DONE,
  output logic [15:0]              WORD_COUNT,
  input  logic                     CPU_RAM_EN,
  input  logic                     CPU_RAM_RW,
  input  logic [ADDRESS_WIDTH-1:0] CPU_ADDRESS,
  input  logic [DATA_WIDTH-1:0]    CPU_DATA_OUT,
  output logic                     HALT,
  output logic                     RAM_EN,
  output logic                     RAM_RW,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
  output logic [DATA_WIDTH-1:0]    DATA_BUS,
  output logic                     DATA_OE
);

  typedef enum logic [1:0] {RUN, HALTING, LOAD, RELEASE} state_e;

  localparam state_e     RESET_STATE = (BOOT_LOAD != 0) ? LOAD : RUN;
  localparam logic       RESET_HALT  = (BOOT_LOAD != 0);
  localparam logic [3:0] SETTLE_INIT = 4'(HALT_SETTLE - 1);

  state_e                   state_q, state_d;
  logic                     halt_q, halt_d;
  logic                     ready_q, ready_d;
  logic                     done_q, done_d;
  logic                     last_q, last_d;
  logic                     wr_q, wr_d;
  logic [3:0]               settle_q, settle_d;
  logic [15:0]              count_q, count_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     accept;
  logic                     cpu_owns;

  assign accept = LOAD_VALID & ready_q;

  always_comb begin
    state_d  = state_q;
    halt_d   = halt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    last_d   = last_q;
    wr_d     = 1'b0;
    settle_d = settle_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      RUN: begin
        halt_d  = 1'b0;
        ready_d = 1'b0;
        if (LOAD_REQ) begin
          state_d  = HALTING;
          halt_d   = 1'b1;
          settle_d = SETTLE_INIT;
        end
      end
      HALTING: begin
        if (settle_q == '0) begin
          state_d = LOAD;
          ready_d = 1'b1;
          last_d  = 1'b0;
          count_d = '0;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      LOAD: begin
        // last_q marks the cycle carrying the final write; RELEASE follows it
        // so the turnaround cycle is never also a write cycle.
        if (last_q) begin
          state_d = RELEASE;
          last_d  = 1'b0;
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
          if (accept) begin
            wr_d    = 1'b1;
            addr_d  = LOAD_ADDR;
            data_d  = LOAD_DATA;
            count_d = count_q + 16'd1;
            if (LOAD_LAST) begin
              ready_d = 1'b0;
              last_d  = 1'b1;
            end
          end
        end
      end
      RELEASE: begin
        state_d = RUN;
        halt_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= RESET_STATE;
      halt_q   <= RESET_HALT;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
      wr_q     <= 1'b0;
      settle_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      halt_q   <= halt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      settle_q <= settle_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Gating with RESET keeps the bus at its idle values while reset is held,
  // even when reset parks the FSM in RUN.
  assign cpu_owns = RESET & ((state_q == RUN) | (state_q == HALTING));

  assign RAM_EN      = cpu_owns ? CPU_RAM_EN   : wr_q;
  assign RAM_RW      = cpu_owns ? CPU_RAM_RW   : ~wr_q;
  assign ADDRESS_BUS = cpu_owns ? CPU_ADDRESS  : addr_q;
  assign DATA_BUS    = cpu_owns ? CPU_DATA_OUT : data_q;
  assign DATA_OE     = cpu_owns ? (CPU_RAM_EN & ~CPU_RAM_RW) : wr_q;

  assign HALT       = halt_q;
  assign LOAD_READY = ready_q;
  assign LOAD_DONE  = done_q;
  assign WORD_COUNT = count_q;

endmodule

// File: doc/bat_amateur_bus_arbiter.md
Name: bat_amateur_bus_arbiter

Overview:
Owns the shared RAM bus (RAM_EN, RAM_RW, ADDRESS_BUS, DATA_BUS) and arbitrates it between the CPU and a program/data loader port.
- While the loader holds the bus, the CPU is frozen via HALT. The arbiter writes the accepted (address, data) words into RAM one per cycle, then hands the bus back and releases HALT.
- This replaces hand-sequenced bench driving of HALT and the RAM bus with a synthesizable boot and reload path.

Parameters:
ADDRESS_WIDTH, 16, width of ADDRESS_BUS, LOAD_ADDR and CPU_ADDRESS
DATA_WIDTH, 16, width of DATA_BUS, LOAD_DATA and CPU_DATA_OUT
HALT_SETTLE, 2, cycles HALT is held before the loader gets the bus (CPU quiesce time); legal range 1..15
BOOT_LOAD, 1, 1 = leave reset in LOAD state (CPU halted); 0 = leave reset in RUN state

Ports:
CLK  in  1  system clock; all state changes on the rising edge
RESET  in  1  asynchronous, active-low reset
LOAD_REQ  in  1  pulse or level; requests the bus for loading
LOAD_VALID  in  1  loader word valid
LOAD_LAST  in  1  qualifies the final word of the load
LOAD_ADDR  in  ADDRESS_WIDTH  RAM address of the word
LOAD_DATA  in  DATA_WIDTH  RAM data of the word
LOAD_READY  out  1  arbiter accepts the word this cycle
LOAD_DONE  out  1  one-cycle pulse when the bus returns to the CPU
WORD_COUNT  out  16  words written since the last entry to LOAD
CPU_RAM_EN  in  1  CPU RAM enable
CPU_RAM_RW  in  1  CPU RAM direction (1 = read, 0 = write)
CPU_ADDRESS  in  ADDRESS_WIDTH  CPU address
CPU_DATA_OUT  in  DATA_WIDTH  CPU write data
HALT  out  1  freezes the CPU
RAM_EN  out  1  RAM enable to the bus
RAM_RW  out  1  RAM direction (1 = read, 0 = write)
ADDRESS_BUS  out  ADDRESS_WIDTH  RAM address
DATA_BUS  out  DATA_WIDTH  RAM write data
DATA_OE  out  1  DATA_BUS is driven; when low, the top level tristates DATA_BUS

Behaviour:
- States: RUN, HALTING, LOAD, RELEASE. Encoding is free.
- Reset (RESET=0, asynchronous):
  - state = LOAD if BOOT_LOAD=1, else RUN
  - HALT = BOOT_LOAD
  - RAM_EN = 0, RAM_RW = 1, ADDRESS_BUS = 0, DATA_BUS = 0, DATA_OE = 0
  - LOAD_READY = 0, LOAD_DONE = 0, WORD_COUNT = 0, settle counter = 0
  - Reset mid-load aborts the load immediately; no partial write is issued after the reset edge.
- RUN:
  - HALT=0, LOAD_READY=0.
  - Bus outputs are combinational pass-through of the CPU inputs. DATA_OE = CPU_RAM_EN & ~CPU_RAM_RW.
  - LOAD_REQ=1 moves to HALTING, asserting HALT and loading the settle counter with HALT_SETTLE-1.
- HALTING:
  - HALT=1. CPU pass-through continues so an in-flight CPU access completes.
  - The counter decrements each cycle; at 0, go to LOAD. HALT therefore precedes loader ownership by exactly HALT_SETTLE cycles.
- LOAD:
  - HALT=1, LOAD_READY=1 (registered, asserted from the first LOAD cycle). CPU inputs are ignored.
  - On entry, WORD_COUNT clears to 0.
  - Accept = LOAD_VALID & LOAD_READY. An accepted word produces a registered write on the next cycle: RAM_EN=1, RAM_RW=0, ADDRESS_BUS=LOAD_ADDR, DATA_BUS=LOAD_DATA, DATA_OE=1.
  - Cycles with no accept: RAM_EN=0, RAM_RW=1, DATA_OE=0, ADDRESS_BUS/DATA_BUS hold their last values.
  - Back-to-back accepts give back-to-back writes (throughput 1 word/cycle, latency 1).
  - WORD_COUNT increments per accept and wraps 0xFFFF->0x0000.
  - Accept with LOAD_LAST=1: LOAD_READY drops the next cycle (together with the final write), and the state goes to RELEASE.
  - LOAD_REQ is ignored while in LOAD.
- RELEASE (1 cycle):
  - RAM_EN=0, RAM_RW=1, DATA_OE=0, HALT still 1. This is the bus turnaround cycle.
  - Next state is RUN, with LOAD_DONE=1 and HALT=0 in the first RUN cycle.
  - If LOAD_REQ=1 during that first RUN cycle, go to HALTING again. No starvation protection is required.
- LOAD_VALID with LOAD_LAST=1 while LOAD_READY=0: not accepted, no effect.
- Exactly one of {CPU, loader} drives the bus in any cycle; RELEASE guarantees a non-driving cycle between loader and CPU ownership.

Test Plan:
- Boot load (BOOT_LOAD=1, HALT_SETTLE=2): release reset, stream (0x0010,1),(0x0011,0),(0x0012,1),(0x0000,0x0010),(0x000D,0x6006),(0x000E,0x400E, LAST) back-to-back -> six RAM writes on consecutive cycles, each 1 cycle after its accept; WORD_COUNT=6; one RELEASE cycle with RAM_EN=0; LOAD_DONE pulses once; HALT falls in the same cycle.
- Gapped stream: LOAD_VALID low every other cycle -> writes only on cycles after accepts; RAM_EN=0 and DATA_OE=0 in the gaps.
- Run-time reload (BOOT_LOAD=0): CPU reading 0x0006, pulse LOAD_REQ -> HALT=1 next cycle; CPU address still visible on ADDRESS_BUS for 2 cycles; then LOAD_READY=1 and CPU_ADDRESS changes no longer reach the bus.
- Reset mid-load: assert RESET=0 after 3 of 5 words -> outputs take their reset values asynchronously; no 4th write; WORD_COUNT=0.
- Wrap: accept 0x10001 words without LAST -> WORD_COUNT=0x0001.
- LOAD_REQ held high through RELEASE -> exactly one RUN cycle (LOAD_DONE=1, HALT=0), then HALTING.
